barrel_shift_right_pipe: RTL and testbench

Pipelined right barrel shifter with valid/ready handshakes on both sides. It supports logical, arithmetic and rotate right shifts. It complements the combinational left shifter and is used where a shift sits on a registered datapath under backpressure. Each shift-amount bit is resolved in its own register stage, so throughput is one word per cycle and latency is $clog2(WIDTH) cycles.

---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_stage.sv | 69 ++++++
 rtl/barrel_shift_right_pipe.sv | 61 ++++++
 tb/tb_barrel_shift_right_pipe.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the pipelined right barrel shifter: shift modes and the
// per-stage payload layout at the default data width.
package shift_pkg;

    localparam int unsigned SHIFT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        SH_LSR  = 2'd0,
        SH_ASR  = 2'd1,
        SH_ROR  = 2'd2,
        SH_RSVD = 2'd3
    } shift_mode_e;

    typedef struct packed {
        logic [SHIFT_W_DEFAULT-1:0]         data;
        logic [$clog2(SHIFT_W_DEFAULT)-1:0] amount;
        shift_mode_e                        mode;
    } stage_payload_t;

endpackage

// File: rtl/shift_stage.sv
// One registered stage of the right barrel shifter: conditionally shifts by
// 2**STAGE according to amount bit STAGE, with valid/ready flow control.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STAGE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH)-1:0] i_amount,
    input  shift_mode_e              i_mode,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(WIDTH)-1:0] o_amount,
    output shift_mode_e              o_mode
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned DIST = 2 ** STAGE;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   amount;
        shift_mode_e      mode;
    } payload_t;

    logic             r_valid;
    payload_t         r_payload;
    logic [WIDTH-1:0] w_shifted;

    // Reserved mode falls into the default arm and shifts logically.
    always_comb begin
        w_shifted = i_data;
        if (i_amount[STAGE]) begin
            case (i_mode)
                SH_ASR:  w_shifted = $signed(i_data) >>> DIST;
                SH_ROR:  w_shifted = (i_data >> DIST) | (i_data << (WIDTH - DIST));
                default: w_shifted = i_data >> DIST;
            endcase
        end
    end

    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_payload.data   <= w_shifted;
                r_payload.amount <= i_amount;
                r_payload.mode   <= i_mode;
            end
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_payload.data;
    assign o_amount = r_payload.amount;
    assign o_mode   = r_payload.mode;

endmodule

// File: rtl/barrel_shift_right_pipe.sv
// Pipelined right barrel shifter (LSR/ASR/ROR): one stage per shift-amount bit,
// combinational ready chain back to in_ready, one word per cycle throughput.
module barrel_shift_right_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shift_amount,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out
);

    logic             w_valid [0:SHW];
    logic             w_ready [0:SHW];
    logic [WIDTH-1:0] w_data  [0:SHW];
    logic [SHW-1:0]   w_amt   [0:SHW];
    shift_mode_e      w_mode  [0:SHW];
    logic             w_unused_tail;

    assign w_valid[0]   = in_valid;
    assign w_data[0]    = data_in;
    assign w_amt[0]     = shift_amount;
    assign w_mode[0]    = shift_mode_e'(mode);
    assign w_ready[SHW] = out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .STAGE (k)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_valid  (w_valid[k]),
            .o_ready  (w_ready[k]),
            .i_data   (w_data[k]),
            .i_amount (w_amt[k]),
            .i_mode   (w_mode[k]),
            .o_valid  (w_valid[k+1]),
            .i_ready  (w_ready[k+1]),
            .o_data   (w_data[k+1]),
            .o_amount (w_amt[k+1]),
            .o_mode   (w_mode[k+1])
        );
    end

    // The last stage's amount and mode have no consumer past the pipeline.
    assign w_unused_tail = ^{w_amt[SHW], w_mode[SHW]};

    assign in_ready  = w_ready[0];
    assign out_valid = w_valid[SHW];
    assign data_out  = w_data[SHW];

endmodule

// File: tb/tb_barrel_shift_right_pipe.sv
// Self-checking bench for barrel_shift_right_pipe (WIDTH 8): directed cases,
// streaming, backpressure, random flow control and mid-flight reset.
module tb_barrel_shift_right_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic [2:0] shift_amount;
    logic [1:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] data_out;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] q[$];

    barrel_shift_right_pipe #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in      (data_in),
        .shift_amount (shift_amount),
        .mode         (mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input int a, input int m);
        logic [15:0] t;
        case (m)
            1:       t = {{8{d[7]}}, d} >> a;
            2:       t = {d, d} >> a;
            default: t = {8'h00, d} >> a;
        endcase
        return t[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Settle, score this cycle's transfers, then advance past the next edge.
    task automatic tick(input bit use_exp = 1'b0, input logic [7:0] exp = 8'h00);
        bit acc, deq;
        #1;
        acc = in_valid && in_ready;
        deq = out_valid && out_ready;
        if (deq) begin
            if (q.size() == 0) chk("unexpected_output", {24'h0, data_out}, 32'hFFFF_FFFF);
            else chk("data_out", {24'h0, data_out}, {24'h0, q.pop_front()});
        end
        if (acc) q.push_back(use_exp ? exp : ref_shift(data_in, int'(shift_amount), int'(mode)));
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m,
                          input logic [7:0] exp, input string tag);
        data_in = d; shift_amount = a; mode = m; in_valid = 1'b1; out_ready = 1'b1;
        tick(1'b1, exp);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {31'h0, out_valid}, 32'h0);
        tick();
        chk({tag, "_lat2"}, {31'h0, out_valid}, 32'h0);
        tick();
        chk({tag, "_lat3"}, {31'h0, out_valid}, 32'h1);
        tick();
        chk({tag, "_drained"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; shift_amount = '0; mode = '0; out_ready = 1'b1;
        #2;
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_data_out", {24'h0, data_out}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);

        single(8'hB4, 3'd3, 2'd0, 8'h16, "b4_lsr3");
        single(8'hB4, 3'd3, 2'd1, 8'hF6, "b4_asr3");
        single(8'hB4, 3'd3, 2'd2, 8'h96, "b4_ror3");
        single(8'h80, 3'd7, 2'd0, 8'h01, "80_lsr7");
        single(8'h80, 3'd7, 2'd1, 8'hFF, "80_asr7");
        single(8'h80, 3'd7, 2'd2, 8'h01, "80_ror7");
        single(8'h5A, 3'd0, 2'd0, 8'h5A, "5a_lsr0");
        single(8'h5A, 3'd0, 2'd1, 8'h5A, "5a_asr0");
        single(8'h5A, 3'd0, 2'd2, 8'h5A, "5a_ror0");
        single(8'hF0, 3'd4, 2'd3, 8'h0F, "f0_rsvd4");

        // Streaming 0x01..0x10 back to back.
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            data_in = 8'(i); shift_amount = 3'($urandom_range(0, 7)); mode = 2'($urandom_range(0, 3));
            in_valid = 1'b1;
            tick();
            chk("stream_in_ready", {31'h0, in_ready}, 32'h1);
            if (i >= 3) chk("stream_out_valid", {31'h0, out_valid}, 32'h1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("stream_empty", q.size(), 32'd0);

        // Backpressure: fill three stages with out_ready low.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'($urandom); shift_amount = 3'($urandom_range(0, 7)); mode = 2'($urandom_range(0, 2));
            in_valid = 1'b1;
            tick();
            chk("bp_fill_in_ready", {31'h0, in_ready}, (i < 2) ? 32'h1 : 32'h0);
        end
        data_in = 8'hA5; shift_amount = 3'd5; mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", {31'h0, out_valid}, 32'h1);
            chk("bp_hold_data", {24'h0, data_out}, {24'h0, q[0]});
            chk("bp_hold_in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'h0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("bp_empty", q.size(), 32'd0);

        // Random valid/ready toggling.
        for (int i = 0; i < 300; i++) begin
            data_in = 8'($urandom); shift_amount = 3'($urandom_range(0, 7)); mode = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("random_empty", q.size(), 32'd0);

        // Reset with three words in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 8'($urandom); shift_amount = 3'($urandom_range(0, 7)); mode = 2'd0;
            in_valid = 1'b1;
            tick();
        end
        chk("pre_reset_valid", {31'h0, out_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("midreset_data_out", {24'h0, data_out}, 32'h0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_reset_no_stale", {31'h0, out_valid}, 32'h0);
        end
        single(8'hC3, 3'd1, 2'd1, 8'hE1, "c3_asr1");
        chk("final_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
